// File: rtl/btn_debouncer_n.sv
// Multi-channel button debouncer: 2-flop synchroniser plus a per-channel stability counter.
// Define BTN_DEBOUNCER_N_EDGE_EN to build the registered press/release pulse outputs.
module btn_debouncer_n #(
  parameter int unsigned N_BTN         = 4,
  parameter int unsigned STABLE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_out,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic             any_pressed
);

  localparam int unsigned   CW      = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  logic [N_BTN-1:0] s0;
  logic [N_BTN-1:0] s1;
  logic [N_BTN-1:0] state;
  logic [N_BTN-1:0] settle;
  logic [CW-1:0]    cnt [N_BTN];

  // settle marks the edge on which a channel's output adopts the synchronised level
  always_comb begin
    settle = '0;
    for (int unsigned i = 0; i < N_BTN; i++) begin
      settle[i] = (s1[i] != state[i]) && (cnt[i] == CNT_MAX);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s0    <= '0;
      s1    <= '0;
      state <= '0;
      for (int unsigned i = 0; i < N_BTN; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s0 <= btn_in;
      s1 <= s0;
      for (int unsigned i = 0; i < N_BTN; i++) begin
        if (s1[i] == state[i]) begin
          cnt[i] <= '0;
        end else if (settle[i]) begin
          cnt[i]   <= '0;
          state[i] <= s1[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

`ifdef BTN_DEBOUNCER_N_EDGE_EN
  logic [N_BTN-1:0] press_q;
  logic [N_BTN-1:0] release_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      press_q   <= '0;
      release_q <= '0;
    end else begin
      press_q   <= settle & s1;
      release_q <= settle & ~s1;
    end
  end

  assign btn_press   = press_q;
  assign btn_release = release_q;
`else
  assign btn_press   = '0;
  assign btn_release = '0;
`endif

  assign btn_out     = state;
  assign any_pressed = |state;

endmodule
